// File: rtl/uart_tx_if.sv
// Byte handshake between the system byte source (master) and the UART
// transmitter (slave).
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with an internal bit-rate divider on sclk.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state   | meaning
// IDLE    | line high, ready for a byte
// START   | start bit (tx=0)
// DATA    | eight data bits, LSB first
// PARITY  | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP    | stop bit (tx=1); last cycle may accept the next byte
module uart_tx #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic     sclk,
   input  logic     srst_n,
   uart_tx_if.slave s_if,
   output logic     tx,
   output logic     busy
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        baud_end;
   logic        ready;
   logic        accept;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   always_comb begin
      baud_end   = (baud_cnt_q == DIV_LAST);
      ready      = (state_q == S_IDLE) || ((state_q == S_STOP) && baud_end);
      accept     = s_if.tx_valid && ready;
      state_d    = state_q;
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         S_IDLE: baud_cnt_d = '0;
         S_START: begin
            if (baud_end) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (baud_end) state_d = S_STOP;
`endif
         S_STOP: if (baud_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // An accept always wins, including in the last STOP cycle (back-to-back).
      if (accept) begin
         state_d    = S_START;
         shreg_d    = s_if.tx_data;
         bit_cnt_d  = '0;
         baud_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
         parity_d   = ^s_if.tx_data;
`endif
      end

      // tx is registered, so it is decoded from the state being entered.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign s_if.tx_ready = ready;
   assign tx            = tx_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle tx/busy/tx_ready waveforms are
// compared against a frame model built from the byte values.
module tb_uart_tx;
   localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CD;

   logic sclk = 1'b0;
   logic srst_n = 1'b0;
   logic tx, busy;
   int   total = 0;
   int   bad = 0;

   uart_tx_if u_if ();

   uart_tx #(.CLK_DIV(CD)) dut (
      .sclk   (sclk),
      .srst_n (srst_n),
      .s_if   (u_if),
      .tx     (tx),
      .busy   (busy)
   );

   always #5 sclk = ~sclk;

   // Bit k of a frame carrying byte b: start, data LSB first, [parity], stop.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (NB == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic [127:0] exp_tx(input logic [7:0] b0, input logic [7:0] b1,
                                           input int nfr, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++) begin
         if (i / FL < nfr) v[i] = frame_bit((i / FL == 0) ? b0 : b1, (i % FL) / CD);
         else              v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [127:0] exp_busy(input int nfr, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = (i < nfr * FL);
      return v;
   endfunction

   function automatic logic [127:0] exp_rdy(input int nfr, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = (i >= nfr * FL) || (i % FL == FL - 1);
      return v;
   endfunction

   // Sample n cycles on falling edges; optionally drop tx_valid or inject a
   // one-cycle tx_valid pulse at given cycle indices.
   task automatic capture(input int n, input int drop_at, input int pulse_at,
                          output logic [127:0] tv, output logic [127:0] bv,
                          output logic [127:0] rv);
      tv = '0; bv = '0; rv = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge sclk);
         tv[i] = tx;
         bv[i] = busy;
         rv[i] = u_if.tx_ready;
         if (i == drop_at) u_if.tx_valid = 1'b0;
         if (pulse_at >= 0 && i == pulse_at + 1) begin
            u_if.tx_valid = 1'b0;
            u_if.tx_data  = 8'($urandom);
         end
         if (i == pulse_at) begin
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = 8'h12;
         end
      end
   endtask

   // Called from a falling edge; returns just after the accepting rising edge.
   task automatic accept_byte(input logic [7:0] b, input bit keep_valid);
      bit ok = 1'b0;
      bit acc;
      u_if.tx_data  = b;
      u_if.tx_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         acc = u_if.tx_ready;
         @(posedge sclk);
         if (acc) begin
            ok = 1'b1;
            break;
         end
         @(negedge sclk);
      end
      #1;
      if (!keep_valid) u_if.tx_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout byte=%h not accepted within 200 cycles", b);
      end
   endtask

   task automatic test_reset();
      logic [127:0] tv, bv, rv;
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = 8'h00;
      srst_n = 1'b0;
      @(negedge sclk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (u_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", u_if.tx_ready); end
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'hFF;
      @(negedge sclk);
      u_if.tx_valid = 1'b0;
      total++; if (tx !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_hs_ignored got tx=%b busy=%b want tx=1 busy=0", tx, busy);
      end
      @(negedge sclk);
      srst_n = 1'b1;
      capture(3 * CD, -1, -1, tv, bv, rv);
      total++; if (tv !== exp_tx(8'h00, 8'h00, 0, 3 * CD) || bv !== exp_busy(0, 3 * CD)) begin
         bad++; $display("FAIL post_reset_idle got tx=%h busy=%h want tx=%h busy=%h",
                         tv, bv, exp_tx(8'h00, 8'h00, 0, 3 * CD), exp_busy(0, 3 * CD));
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      logic [127:0] tv, bv, rv;
      accept_byte(b, 1'b0);
      capture(FL + CD, -1, -1, tv, bv, rv);
      total++; if (tv !== exp_tx(b, 8'h00, 1, FL + CD)) begin
         bad++; $display("FAIL single_tx byte=%h got=%h want=%h", b, tv, exp_tx(b, 8'h00, 1, FL + CD));
      end
      total++; if (bv !== exp_busy(1, FL + CD)) begin
         bad++; $display("FAIL single_busy byte=%h got=%h want=%h", b, bv, exp_busy(1, FL + CD));
      end
      total++; if (rv !== exp_rdy(1, FL + CD)) begin
         bad++; $display("FAIL single_ready byte=%h got=%h want=%h", b, rv, exp_rdy(1, FL + CD));
      end
   endtask

   task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
      logic [127:0] tv, bv, rv;
      accept_byte(b0, 1'b1);
      u_if.tx_data = b1;
      capture(2 * FL + CD, FL, -1, tv, bv, rv);
      total++; if (tv !== exp_tx(b0, b1, 2, 2 * FL + CD)) begin
         bad++; $display("FAIL b2b_tx bytes=%h,%h got=%h want=%h", b0, b1, tv, exp_tx(b0, b1, 2, 2 * FL + CD));
      end
      total++; if (bv !== exp_busy(2, 2 * FL + CD)) begin
         bad++; $display("FAIL b2b_busy got=%h want=%h", bv, exp_busy(2, 2 * FL + CD));
      end
      total++; if (rv !== exp_rdy(2, 2 * FL + CD)) begin
         bad++; $display("FAIL b2b_ready got=%h want=%h", rv, exp_rdy(2, 2 * FL + CD));
      end
   endtask

   task automatic test_holdoff(input logic [7:0] b);
      logic [127:0] tv, bv, rv;
      accept_byte(b, 1'b0);
      capture(FL + 3 * CD, -1, 10, tv, bv, rv);
      total++; if (tv !== exp_tx(b, 8'h00, 1, FL + 3 * CD)) begin
         bad++; $display("FAIL holdoff_tx got=%h want=%h", tv, exp_tx(b, 8'h00, 1, FL + 3 * CD));
      end
      total++; if (bv !== exp_busy(1, FL + 3 * CD)) begin
         bad++; $display("FAIL holdoff_busy got=%h want=%h", bv, exp_busy(1, FL + 3 * CD));
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] tv, bv, rv;
      accept_byte(8'h55, 1'b0);
      capture(4 * CD + 1, -1, -1, tv, bv, rv);
      total++; if (tv !== exp_tx(8'h55, 8'h00, 1, 4 * CD + 1)) begin
         bad++; $display("FAIL mid_prefix_tx got=%h want=%h", tv, exp_tx(8'h55, 8'h00, 1, 4 * CD + 1));
      end
      srst_n = 1'b0;
      #1;
      total++; if (tx !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset_async got tx=%b busy=%b want tx=1 busy=0", tx, busy);
      end
      @(negedge sclk);
      @(negedge sclk);
      srst_n = 1'b1;
      capture(FL, -1, -1, tv, bv, rv);
      total++; if (tv !== exp_tx(8'h00, 8'h00, 0, FL) || bv !== exp_busy(0, FL)) begin
         bad++; $display("FAIL mid_after_release got tx=%h busy=%h want tx=%h busy=%h",
                         tv, bv, exp_tx(8'h00, 8'h00, 0, FL), exp_busy(0, FL));
      end
      test_single(8'hA5);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r0, r1;
      test_reset();
      test_single(8'hB9);
      test_single(8'h00);
      test_back_to_back(8'hB9, 8'hCB);
      test_holdoff(8'h3C);
      test_reset_mid();
      for (int r = 0; r < 8; r++) begin
         repeat ($urandom_range(0, 5)) @(negedge sclk);
         r0 = 8'($urandom);
         test_single(r0);
      end
      for (int r = 0; r < 3; r++) begin
         r0 = 8'($urandom);
         r1 = 8'($urandom);
         test_back_to_back(r0, r1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter. It serialises one byte per `tx_valid`/`tx_ready` handshake into an 8-N-1 frame on `tx`: start bit 0, eight data bits LSB-first, stop bit 1. It is the transmit counterpart of the team's `uart` receiver and sits between the system byte source and the board TX pin. Bit timing comes from an internal divider on `sclk`, so no external bit clock is required.

## Interface
- `CLK_DIV`, default 16: `sclk` cycles per bit. Legal range is 2..65535.
- `sclk`, input, 1 bit: system clock. All logic is on the rising edge.
- `srst_n`, input, 1 bit: asynchronous, active-low reset.
- `tx_data`, input, 8 bits: byte to send. Sampled only on the accept cycle.
- `tx_valid`, input, 1 bit: `tx_data` is valid.
- `tx_ready`, output, 1 bit: the block can accept a byte this cycle.
- `tx`, output, 1 bit: serial line. Idles high.
- `busy`, output, 1 bit: a frame is in progress (any state other than IDLE).

## Operation
- **States:**
  - IDLE → START → DATA → (PARITY, only with the macro) → STOP → IDLE or START.
- **Accept:** a handshake occurs when `tx_valid && tx_ready` is high at a rising edge of `sclk`.
  - On accept, `tx_data` is latched into the shift register.
  - The bit counter and the divider count `baud_cnt` are both cleared.
- **Divider:**
  - `baud_cnt` counts 0..CLK_DIV-1. Each bit lasts exactly CLK_DIV cycles.
  - A state or bit advances when `baud_cnt == CLK_DIV-1`, and `baud_cnt` then wraps to 0.
- **Per-state behaviour:**
  - START drives `tx=0`.
  - DATA drives `tx = shreg[0]` and shifts the register right at each bit end. After bit index 7 it moves to PARITY or STOP.
  - STOP drives `tx=1`.
- **`tx_ready`:**
  - Equals 1 in IDLE.
  - Also equals 1 in the last cycle of STOP (`baud_cnt == CLK_DIV-1`).
  - Equals 0 everywhere else.
- **Back-to-back frames:** an accept in the last STOP cycle goes directly to START. There is no idle cycle between frames.
- **No accept at the end of STOP:** the FSM returns to IDLE, and `tx` stays 1.
- **`tx_data` changes:** changes to `tx_data` mid-frame have no effect on the frame in progress.
- **`tx_valid` dropped early:** if `tx_valid` drops before it is accepted, nothing is sent. No byte is ever lost once it has been accepted.

## Timing
- **Reset values:**
  - `tx=1`, `busy=0`.
  - State is IDLE, so `tx_ready=1` combinationally.
  - Handshakes while `srst_n=0` are ignored.
- **Output registering:** `tx` is registered.
  - The start bit appears on the edge that performs the accept. Latency from accept to `tx` falling is one cycle.
- **`busy`:** registered. It rises on the accept edge and falls on the edge that returns the FSM to IDLE.
- **Frame length:**
  - 10·CLK_DIV cycles without parity.
  - 11·CLK_DIV cycles with parity.
  - N back-to-back bytes occupy exactly N·10·CLK_DIV cycles.
- **Reset mid-frame:** the frame aborts immediately. `tx` goes to 1 asynchronously, the latched byte is discarded, and nothing resumes after reset is released.
- **Simultaneous events:** `tx_valid` arriving in the same cycle the FSM reaches STOP end is accepted (back-to-back case). In any other cycle it waits.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The PARITY state is inserted after DATA. It drives `tx` to even parity, the XOR of the 8 latched bits, for CLK_DIV cycles.
  - Frame length becomes 11·CLK_DIV.
- **`UART_TX_PARITY_EN` undefined:**
  - The PARITY state and the parity logic are absent.
  - Frame is 8-N-1 at 10·CLK_DIV.

## Test plan
- **Single byte:** CLK_DIV=4, send 0xB9.
  - Expected `tx`, 4 cycles per bit: 0,1,0,0,1,1,1,0,1,1.
  - `busy` is high for 40 cycles, then `tx` stays 1.
- **Back-to-back:** hold `tx_valid` with 0xB9 then 0xCB.
  - The second byte is accepted in the last STOP cycle of the first.
  - 80 contiguous frame cycles with no idle bit between frames.
  - Second frame bits: 0,1,1,0,1,0,0,1,1,1.
- **Reset after power-up:** `srst_n` low for 3 cycles.
  - During reset: `tx=1`, `busy=0`, `tx_ready=1`.
  - A `tx_valid` pulse asserted during reset produces no frame.
- **Reset mid-frame:** assert `srst_n=0` during data bit 3 of 0x55.
  - `tx` goes to 1 immediately.
  - After release, the line stays idle until a new handshake.
  - A new 0xA5 then transmits correctly.
- **Handshake hold-off:** pulse `tx_valid` mid-frame with 0x12 for 1 cycle.
  - `tx_ready=0` at that time, so the byte is not sent.
  - Only the original frame appears.
- **Parity** (`UART_TX_PARITY_EN` defined, CLK_DIV=4):
  - 0xB9 gives parity bit 1, with the frame 0,1,0,0,1,1,1,0,1,1,1 over 44 cycles.
  - 0x00 gives parity bit 0.
